tdm_mux_framer: RTL

- Time-division multiplexer: accepts one parallel frame of LANES words and emits them one word per beat, in lane order, on a single serial word channel.
- Tags each beat with its lane index and start/end-of-frame flags.
- It is the collecting end of the team's 1:N demux distribution path; a downstream 1:N demux uses out_sel to route each word back to its lane.

---
 rtl/tdm_mux_framer_pkg.sv | 18 +
 rtl/tdm_mux_framer_if.sv | 38 +++
 rtl/tdm_mux_framer_lane_select.sv | 21 ++
 rtl/tdm_mux_framer.sv | 101 ++++++++++
 4 files changed

// File: rtl/tdm_mux_framer_pkg.sv
// Shared definitions for the TDM mux framer and its matching demux.
// Parity output option: TDM_PARITY_EN.
package tdm_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Lane index width; the demux side calls this too, so both ends agree on out_sel width.
  function automatic int sel_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/tdm_mux_framer_if.sv
// Frame-in / word-out channel of the TDM mux framer.
// out_par exists only when TDM_PARITY_EN is defined.
interface tdm_mux_framer_if #(
  parameter int LANES = tdm_pkg::DEF_LANES,
  parameter int WIDTH = tdm_pkg::DEF_WIDTH
);
  localparam int SEL_W = tdm_pkg::sel_width(LANES);

  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sof;
  logic                   out_eof;
`ifdef TDM_PARITY_EN
  logic                   out_par;
`endif

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid, out_sof, out_eof
`ifdef TDM_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid, out_sof, out_eof
`ifdef TDM_PARITY_EN
    , input out_par
`endif
  );

endinterface

// File: rtl/tdm_mux_framer_lane_select.sv
// Combinational LANES:1 word selector; mux counterpart of the lane demux primitive.
module lane_select
  import tdm_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [LANES*WIDTH-1:0]       i_frame,
  input  logic [sel_width(LANES)-1:0]  i_slot,
  output logic [WIDTH-1:0]             o_word
);
  localparam int SEL_W = sel_width(LANES);

  always_comb begin
    o_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_slot == SEL_W'(k)) o_word = i_frame[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/tdm_mux_framer.sv
// Serialises one LANES-word frame into lane-tagged beats with sof/eof flags.
// Optional registered even-parity output out_par under TDM_PARITY_EN.
module tdm_mux_framer
  import tdm_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  tdm_mux_framer_if.slave  bus
);
  localparam int SEL_W = sel_width(LANES);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

  state_t                 r_state, w_state_nxt;
  logic [SEL_W-1:0]       r_slot, w_slot_nxt;
  logic [LANES*WIDTH-1:0] r_frame, w_frame_nxt;
  logic [WIDTH-1:0]       r_out_data;
  logic [WIDTH-1:0]       w_word_nxt;
  logic                   w_last;
  logic                   w_in_ready;

  assign w_last = (r_slot == LAST_SLOT);

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_frame_nxt = r_frame;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_frame_nxt = bus.in_data;
          w_slot_nxt  = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_in_ready = bus.out_ready && w_last;
        if (bus.out_ready) begin
          if (!w_last) begin
            w_slot_nxt = r_slot + 1'b1;
          end else if (bus.in_valid) begin
            // back-to-back frame: reload on the eof handshake, no bubble
            w_frame_nxt = bus.in_data;
            w_slot_nxt  = '0;
          end else begin
            w_slot_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Select the word for the next cycle so out_data (and parity) come straight from flops.
  lane_select #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_lane_select (
    .i_frame (w_frame_nxt),
    .i_slot  (w_slot_nxt),
    .o_word  (w_word_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_frame    <= '0;
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_frame    <= w_frame_nxt;
      r_out_data <= (w_state_nxt == ST_SEND) ? w_word_nxt : '0;
    end
  end

`ifdef TDM_PARITY_EN
  logic r_out_par;

  always_ff @(posedge clk) begin
    if (rst) r_out_par <= 1'b0;
    else     r_out_par <= (w_state_nxt == ST_SEND) ? ^w_word_nxt : 1'b0;
  end

  assign bus.out_par = r_out_par;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_SEND);
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_slot;
  assign bus.out_sof   = (r_state == ST_SEND) && (r_slot == '0);
  assign bus.out_eof   = (r_state == ST_SEND) && w_last;

endmodule
